// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: valid/ready command in,
// one bus cycle out, valid/ready response back, with an ACK timeout.
module wb_master_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [15:0] xfer_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic tmo_hit(input logic [CNT_W-1:0] cnt);
    return cnt == TMO_LAST;
  endfunction

  function automatic logic [31:0] rsp_data(input logic we, input logic [31:0] rd);
    return we ? 32'h0 : rd;
  endfunction

  state_e             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [15:0]        xfer_q, xfer_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    tmo_cnt_d   = tmo_cnt_q;
    xfer_d      = xfer_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && rdy_q) begin
          we_d      = cmd_we_i;
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          sel_d     = cmd_sel_i;
          cyc_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = BUS;
        end
      end
      BUS: begin
        // ACK is checked first so a late ACK on the final STB cycle is not an error
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = rsp_data(we_q, wbm_dat_i);
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          xfer_d      = xfer_q + 16'd1;
          state_d     = RESP;
        end else if (tmo_hit(tmo_cnt_q)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          xfer_d      = xfer_q + 16'd1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered off the next state so it never follows an input combinationally
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      tmo_cnt_q   <= '0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      tmo_cnt_q   <= tmo_cnt_d;
      xfer_q      <= xfer_d;
    end
  end

  assign cmd_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign xfer_cnt_o  = xfer_q;

endmodule
